// File: rtl/cpu_pkg.sv
// Shared opcode constants, FSM state type and next-PC select codes for the CPU control unit.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] FUNCT_ADD = 6'h20;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } ctrl_state_t;

  typedef enum logic [1:0] {
    NPC_HOLD,
    NPC_INC,
    NPC_BR,
    NPC_J
  } npc_sel_t;

endpackage

// File: rtl/cpu_next_pc.sv
// Combinational next-PC select: hold, +1, branch (pc + sext(imm)) or jump (splice 26-bit target).
module cpu_next_pc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [15:0]       i_imm,
  input  logic [25:0]       i_target,
  input  npc_sel_t          i_sel,
  output logic [ADDR_W-1:0] o_pc
);

  logic signed [15:0]       w_imm_s;
  logic signed [ADDR_W-1:0] w_imm_ext;
  logic [ADDR_W-1:0]        w_tgt_ext;
  logic [ADDR_W-1:0]        w_hi_mask;

  assign w_imm_s   = i_imm;
  assign w_imm_ext = ADDR_W'(w_imm_s);
  assign w_tgt_ext = ADDR_W'(i_target);
  // Mask collapses to zero when ADDR_W <= 26, so the jump target is simply zero-extended.
  assign w_hi_mask = {ADDR_W{1'b1}} << 26;

  always_comb begin
    o_pc = i_pc;
    case (i_sel)
      NPC_HOLD: o_pc = i_pc;
      NPC_INC:  o_pc = i_pc + ADDR_W'(1);
      NPC_BR:   o_pc = i_pc + w_imm_ext;
      NPC_J:    o_pc = (i_pc & w_hi_mask) | w_tgt_ext;
      default:  o_pc = i_pc;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle CPU control unit: owns PC/IR, sequences fetch, decode, execute, memory and writeback.
module cpu_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              fetch_req,
  input  logic              fetch_ack,
  input  logic [31:0]       instruction,
  output logic [ADDR_W-1:0] pc,
  output logic [4:0]        rf_ra,
  output logic [4:0]        rf_rb,
  output logic              rf_we,
  output logic [4:0]        rf_wa,
  output logic              wb_sel,
  output logic              alu_b_sel,
  output logic [5:0]        alu_funct,
  input  logic              alu_zero,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic              illegal,
  output logic [31:0]       retire_cnt
);

  ctrl_state_t       r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_ir;
  logic [31:0]       r_retire;
  logic              r_illegal;
  logic              r_fetch_req;
  logic              r_mem_req;
  logic              r_mem_we;
  logic              r_rf_we;
  logic              r_wb_sel;
  logic              r_alu_b_sel;
  logic [5:0]        r_alu_funct;

  logic [5:0]        w_op;
  npc_sel_t          w_npc_sel;
  logic [ADDR_W-1:0] w_npc;

  assign w_op = r_ir[31:26];

  always_comb begin
    w_npc_sel = NPC_HOLD;
    if (r_state == S_FETCH) begin
      w_npc_sel = NPC_INC;
    end else if (r_state == S_EXEC) begin
      if (w_op == OP_J)                   w_npc_sel = NPC_J;
      else if (w_op == OP_BEQ && alu_zero) w_npc_sel = NPC_BR;
    end
  end

  cpu_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
    .i_pc     (r_pc),
    .i_imm    (r_ir[15:0]),
    .i_target (r_ir[25:0]),
    .i_sel    (w_npc_sel),
    .o_pc     (w_npc)
  );

  // Every output is registered: strobes are set on the transition into the state that owns them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_ir        <= '0;
      r_retire    <= '0;
      r_illegal   <= 1'b0;
      r_fetch_req <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_rf_we     <= 1'b0;
      r_wb_sel    <= 1'b0;
      r_alu_b_sel <= 1'b0;
      r_alu_funct <= FUNCT_ADD;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_fetch_req <= 1'b1;
          if (fetch_ack && r_fetch_req) begin
            r_ir        <= instruction;
            r_pc        <= w_npc;
            r_fetch_req <= 1'b0;
            r_state     <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_state     <= S_EXEC;
          r_alu_b_sel <= 1'b0;
          r_alu_funct <= FUNCT_ADD;
          case (w_op)
            OP_RTYPE:     r_alu_funct <= r_ir[5:0];
            OP_LW, OP_SW: r_alu_b_sel <= 1'b1;
            OP_BEQ, OP_J: r_alu_b_sel <= 1'b0;
            default: begin
              r_state   <= S_TRAP;
              r_illegal <= 1'b1;
            end
          endcase
        end
        S_EXEC: begin
          case (w_op)
            OP_RTYPE: begin
              r_rf_we  <= 1'b1;
              r_wb_sel <= 1'b0;
              r_state  <= S_WB;
            end
            OP_LW, OP_SW: begin
              r_mem_req <= 1'b1;
              r_mem_we  <= (w_op == OP_SW);
              r_state   <= S_MEM;
            end
            default: begin
              r_pc        <= w_npc;
              r_retire    <= r_retire + 32'd1;
              r_fetch_req <= 1'b1;
              r_state     <= S_FETCH;
            end
          endcase
        end
        S_MEM: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (w_op == OP_SW) begin
              r_retire    <= r_retire + 32'd1;
              r_fetch_req <= 1'b1;
              r_state     <= S_FETCH;
            end else begin
              r_rf_we  <= 1'b1;
              r_wb_sel <= 1'b1;
              r_state  <= S_WB;
            end
          end
        end
        S_WB: begin
          r_rf_we     <= 1'b0;
          r_wb_sel    <= 1'b0;
          r_retire    <= r_retire + 32'd1;
          r_fetch_req <= 1'b1;
          r_state     <= S_FETCH;
        end
        S_TRAP: begin
          r_fetch_req <= 1'b0;
          r_mem_req   <= 1'b0;
          r_mem_we    <= 1'b0;
          r_rf_we     <= 1'b0;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign fetch_req  = r_fetch_req;
  assign pc         = r_pc;
  assign rf_ra      = r_ir[25:21];
  assign rf_rb      = r_ir[20:16];
  assign rf_we      = r_rf_we;
  assign rf_wa      = (w_op == OP_LW) ? r_ir[20:16] : r_ir[15:11];
  assign wb_sel     = r_wb_sel;
  assign alu_b_sel  = r_alu_b_sel;
  assign alu_funct  = r_alu_funct;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign illegal    = r_illegal;
  assign retire_cnt = r_retire;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: directed scenarios plus randomized instruction stream vs. a reference model.
module tb_cpu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req, fetch_ack;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [4:0]  rf_ra, rf_rb, rf_wa;
  logic        rf_we, wb_sel, alu_b_sel, alu_zero;
  logic [5:0]  alu_funct;
  logic        mem_req, mem_we, mem_ack, illegal;
  logic [31:0] retire_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ret;

  always #5 clk = ~clk;

  cpu_ctrl_fsm dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_ack(fetch_ack), .instruction(instruction),
    .pc(pc), .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_we(rf_we), .rf_wa(rf_wa),
    .wb_sel(wb_sel), .alu_b_sel(alu_b_sel), .alu_funct(alu_funct), .alu_zero(alu_zero),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
    .illegal(illegal), .retire_cnt(retire_cnt)
  );

  task automatic do_reset();
    reset = 1'b1; fetch_ack = 1'b0; mem_ack = 1'b0; instruction = '0; alu_zero = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    m_pc = 32'd0; m_ret = 32'd0;
  endtask

  // Runs one instruction through the DUT and compares its observable behaviour with the model.
  task automatic run_instr(input logic [31:0] ins, input int fd, input int md, input logic z, input string nm);
    logic [5:0] op;
    logic [15:0] imm;
    int exp_cyc, exp_we, exp_memc, cyc, wec, memc, n;
    logic [4:0] exp_wa, wa_seen;
    logic exp_wbs, exp_mwe, exp_bsel, chk_alu, wbs_seen, mwe_seen, bsel3, ra_bad, fr_bad, hold_bad;
    logic [5:0] exp_fn, fn3;
    op = ins[31:26]; imm = ins[15:0];
    exp_we = 0; exp_wa = '0; exp_wbs = 1'b0; exp_memc = 0; exp_mwe = 1'b0;
    exp_bsel = 1'b0; exp_fn = 6'h20; chk_alu = 1'b1; exp_cyc = 3;
    cyc = 0; wec = 0; memc = 0; wa_seen = '0; wbs_seen = 1'b0; mwe_seen = 1'b0;
    bsel3 = 1'b0; fn3 = '0; ra_bad = 1'b0; fr_bad = 1'b0; hold_bad = 1'b0;
    alu_zero = z;

    n = 0;
    while (fetch_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (fetch_req !== 1'b1) begin
      errors++; $display("FAIL %s fetch_req_wait got %b need 1", nm, fetch_req);
      return;
    end
    checks++;
    if (pc !== m_pc) begin errors++; $display("FAIL %s pc_at_fetch got %h need %h", nm, pc, m_pc); end

    // Model: pc advances by one word at fetch, then opcode-specific effects.
    m_pc = m_pc + 32'd1;
    case (op)
      6'h00: begin exp_cyc = 4; exp_we = 1; exp_wa = ins[15:11]; exp_fn = ins[5:0]; end
      6'h23: begin exp_cyc = 5 + md; exp_we = 1; exp_wa = ins[20:16]; exp_wbs = 1'b1;
                   exp_memc = md + 1; exp_bsel = 1'b1; end
      6'h2B: begin exp_cyc = 4 + md; exp_memc = md + 1; exp_mwe = 1'b1; exp_bsel = 1'b1; end
      6'h04: begin exp_cyc = 3; if (z) m_pc = m_pc + {{16{imm[15]}}, imm}; end
      default: begin exp_cyc = 3; chk_alu = 1'b0; m_pc = {m_pc[31:26], ins[25:0]}; end
    endcase
    m_ret = m_ret + 32'd1;

    for (int i = 0; i < fd; i++) begin
      mem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (fetch_req !== 1'b1) fr_bad = 1'b1;
    end
    mem_ack = 1'b0; fetch_ack = 1'b1; instruction = ins; cyc = 1;
    @(negedge clk);
    fetch_ack = 1'b0; instruction = $urandom;

    for (n = 0; n < 40; n++) begin
      if (fetch_req === 1'b1) break;
      cyc++;
      if (rf_ra !== ins[25:21] || rf_rb !== ins[20:16]) ra_bad = 1'b1;
      if (cyc == 3) begin bsel3 = alu_b_sel; fn3 = alu_funct; end
      if (rf_we === 1'b1) begin wec++; wa_seen = rf_wa; wbs_seen = wb_sel; end
      if (mem_req === 1'b1) begin
        memc++; mwe_seen = mem_we;
        if (alu_b_sel !== 1'b1 || alu_funct !== 6'h20) hold_bad = 1'b1;
        mem_ack = (memc == md + 1);
      end else begin
        mem_ack = 1'($urandom_range(0, 1));
      end
      fetch_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    fetch_ack = 1'b0; mem_ack = 1'b0;

    checks++;
    if (cyc !== exp_cyc || fetch_req !== 1'b1) begin
      errors++; $display("FAIL %s latency got %0d need %0d (fetch_req=%b)", nm, cyc, exp_cyc, fetch_req);
    end
    checks++;
    if (pc !== m_pc) begin errors++; $display("FAIL %s pc got %h need %h", nm, pc, m_pc); end
    checks++;
    if (retire_cnt !== m_ret) begin errors++; $display("FAIL %s retire_cnt got %0d need %0d", nm, retire_cnt, m_ret); end
    checks++;
    if (wec !== exp_we) begin errors++; $display("FAIL %s rf_we_cycles got %0d need %0d", nm, wec, exp_we); end
    if (exp_we == 1) begin
      checks++;
      if (wa_seen !== exp_wa || wbs_seen !== exp_wbs) begin
        errors++; $display("FAIL %s rf_wa/wb_sel got %0d/%b need %0d/%b", nm, wa_seen, wbs_seen, exp_wa, exp_wbs);
      end
    end
    checks++;
    if (memc !== exp_memc) begin errors++; $display("FAIL %s mem_req_cycles got %0d need %0d", nm, memc, exp_memc); end
    if (exp_memc > 0) begin
      checks++;
      if (mwe_seen !== exp_mwe || hold_bad) begin
        errors++; $display("FAIL %s mem_we/alu_hold got %b/%b need %b/0", nm, mwe_seen, hold_bad, exp_mwe);
      end
    end
    if (chk_alu) begin
      checks++;
      if (bsel3 !== exp_bsel || fn3 !== exp_fn) begin
        errors++; $display("FAIL %s alu_ctrl got %b/%h need %b/%h", nm, bsel3, fn3, exp_bsel, exp_fn);
      end
    end
    checks++;
    if (ra_bad || fr_bad || illegal !== 1'b0) begin
      errors++; $display("FAIL %s stability ra_bad=%b fr_drop=%b illegal=%b need 0/0/0", nm, ra_bad, fr_bad, illegal);
    end
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({fetch_req, mem_req, mem_we, rf_we, wb_sel, alu_b_sel, illegal} !== 7'b0) begin
      errors++; $display("FAIL reset_strobes got %b need 0000000",
                         {fetch_req, mem_req, mem_we, rf_we, wb_sel, alu_b_sel, illegal});
    end
    checks++;
    if (pc !== 32'd0 || retire_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_pc_ret got %h/%h need 0/0", pc, retire_cnt);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (fetch_req !== 1'b1) begin errors++; $display("FAIL reset_release_fetch got %b need 1", fetch_req); end
  endtask

  task automatic test_rtype();
    run_instr(32'h0022_1820, 0, 0, 1'b0, "rtype_add");
    checks++;
    if (pc !== 32'd1 || retire_cnt !== 32'd1) begin
      errors++; $display("FAIL rtype_add_abs got pc=%h ret=%0d need 1/1", pc, retire_cnt);
    end
  endtask

  task automatic test_lw_sw();
    run_instr({6'h23, 5'd4, 5'd7, 16'h0008}, 1, 3, 1'b0, "lw_wait3");
    run_instr({6'h2B, 5'd4, 5'd9, 16'h000C}, 0, 2, 1'b1, "sw_wait2");
    run_instr({6'h23, 5'd0, 5'd0, 16'hFFFF}, 0, 0, 1'b0, "lw_rt0");
  endtask

  task automatic test_beq();
    run_instr({6'h02, 26'd5}, 0, 0, 1'b0, "j_to5");
    run_instr({6'h04, 5'd1, 5'd2, 16'hFFFE}, 0, 0, 1'b1, "beq_taken");
    checks++;
    if (pc !== 32'd4) begin errors++; $display("FAIL beq_taken_abs got %h need 4", pc); end
    run_instr({6'h02, 26'd5}, 0, 0, 1'b0, "j_to5b");
    run_instr({6'h04, 5'd1, 5'd2, 16'hFFFE}, 2, 0, 1'b0, "beq_not_taken");
    checks++;
    if (pc !== 32'd6) begin errors++; $display("FAIL beq_not_taken_abs got %h need 6", pc); end
  endtask

  task automatic test_jump();
    run_instr({6'h02, 26'h40}, 0, 0, 1'b0, "j_to40");
    run_instr({6'h02, 26'h10}, 1, 0, 1'b1, "j_to10");
    checks++;
    if (pc !== 32'h10) begin errors++; $display("FAIL j_abs got %h need 10", pc); end
  endtask

  task automatic test_random();
    logic [5:0] ops [5];
    logic [31:0] r;
    ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04; ops[4] = 6'h02;
    for (int k = 0; k < 40; k++) begin
      r = $urandom;
      run_instr({ops[$urandom_range(0, 4)], r[25:0]}, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_reset_mid_mem();
    int n;
    n = 0;
    while (fetch_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    fetch_ack = 1'b1; instruction = {6'h23, 5'd3, 5'd5, 16'h0004};
    @(negedge clk);
    fetch_ack = 1'b0;
    n = 0;
    while (mem_req !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL midmem_reach got %b need 1", mem_req); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || fetch_req !== 1'b0 || pc !== 32'd0) begin
      errors++; $display("FAIL midmem_reset got mem_req=%b fetch_req=%b pc=%h need 0/0/0", mem_req, fetch_req, pc);
    end
    @(negedge clk);
    reset = 1'b0; m_pc = 32'd0; m_ret = 32'd0;
    @(negedge clk);
    checks++;
    if (fetch_req !== 1'b1) begin errors++; $display("FAIL midmem_release got %b need 1", fetch_req); end
    run_instr(32'h0022_1820, 0, 0, 1'b0, "after_reset_rtype");
  endtask

  task automatic test_trap();
    int n, bad;
    logic [31:0] frozen;
    n = 0; bad = 0;
    while (fetch_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    frozen = m_pc + 32'd1;
    fetch_ack = 1'b1; instruction = {6'h3F, 26'h155_5555};
    @(negedge clk);
    fetch_ack = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      fetch_ack = 1'($urandom_range(0, 1)); mem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (illegal !== 1'b1 || fetch_req !== 1'b0 || mem_req !== 1'b0 || rf_we !== 1'b0 || pc !== frozen) bad++;
    end
    fetch_ack = 1'b0; mem_ack = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL trap_hold bad_cycles got %0d need 0", bad); end
    checks++;
    if (retire_cnt !== m_ret) begin errors++; $display("FAIL trap_retire got %0d need %0d", retire_cnt, m_ret); end
    do_reset();
    checks++;
    if (illegal !== 1'b0 || pc !== 32'd0) begin
      errors++; $display("FAIL trap_reset_clear got illegal=%b pc=%h need 0/0", illegal, pc);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_sw();
    test_beq();
    test_jump();
    test_random();
    test_reset_mid_mem();
    test_trap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
Multi-cycle control unit that sequences the single-cycle-free CPU datapath: fetcher, decoder, register file, ALU and word RAM.
- Owns the program counter and the instruction register.
- Drives fetch and memory request/acknowledge handshakes.
- Drives register-file, ALU and writeback steering for the five supported opcodes: R-type, lw, sw, beq, j.
- Sits between the fetcher/RAM ports and the register file/ALU in the CPU top.

Parameters:
ADDR_W, 32, PC and word-address width; PC counts 32b words.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
fetch_req  out  1  request instruction at pc
fetch_ack  in  1  instruction valid this cycle
instruction  in  32  fetched word, sampled when fetch_ack=1
pc  out  ADDR_W  current program counter
rf_ra  out  5  register-file read port A index (IR rs)
rf_rb  out  5  register-file read port B index (IR rt)
rf_we  out  1  register-file write enable, 1-cycle pulse
rf_wa  out  5  write index: rd for R-type, rt for lw
wb_sel  out  1  0 = ALU result, 1 = RAM read data
alu_b_sel  out  1  0 = register B, 1 = sign-extended imm
alu_funct  out  6  R-type funct; 6'h20 (add) for lw/sw/beq
alu_zero  in  1  ALU operands equal
mem_req  out  1  RAM access request; address = ALU output
mem_we  out  1  1 = store (sw), valid with mem_req
mem_ack  in  1  RAM access complete
illegal  out  1  sticky: unsupported opcode trapped
retire_cnt  out  32  instructions completed, wraps at 2^32

Behaviour:
- Reset values: state FETCH, pc = RESET_PC, IR = 0, retire_cnt = 0, illegal = 0. All strobes (fetch_req, mem_req, mem_we, rf_we) are 0; alu_b_sel and wb_sel are 0.
- Reset mid-operation aborts any outstanding fetch or memory access. Any ack arriving in a state that is not waiting for it is ignored.
- States are FETCH, DECODE, EXEC, MEM, WB and TRAP.
- FETCH:
  - fetch_req = 1 and stays high until fetch_ack.
  - On fetch_ack: IR <= instruction, pc <= pc + 1 (mod 2^ADDR_W), go to DECODE.
  - fetch_req drops the cycle after ack.
- DECODE: one cycle. rf_ra/rf_rb come from IR and are held stable through EXEC, MEM and WB. An unsupported opcode goes to TRAP.
- EXEC: one cycle.
  - R-type: alu_b_sel = 0, alu_funct = IR funct, then go to WB.
  - lw/sw: alu_b_sel = 1, alu_funct = add, then go to MEM.
  - beq: alu_b_sel = 0. If alu_zero, pc <= pc + sext(imm), where pc is already incremented. Retire and go to FETCH.
  - j: pc <= {pc[ADDR_W-1:26], addr[25:0]} (zero-extended when ADDR_W ≤ 26). Retire and go to FETCH.
- MEM:
  - mem_req = 1 until mem_ack; mem_we = (opcode == sw). ALU controls are held.
  - sw: retire on ack and go to FETCH.
  - lw: go to WB on ack.
- WB:
  - rf_we = 1 for exactly one cycle; wb_sel = 1 for lw, 0 otherwise.
  - rf_wa is rd for R-type, rt for lw.
  - Retire and go to FETCH. Writes to index 0 are not suppressed; register policy is owned by the register file.
- Retire: retire_cnt += 1 in the completing cycle.
- Minimum latency with zero-wait acks:
  - R-type 4 cycles
  - lw 5 cycles
  - sw 4 cycles
  - beq/j 3 cycles
- TRAP: illegal = 1, all strobes are 0, pc frozen. Leaves only via reset.
- Simultaneous fetch_ack and mem_ack cannot conflict: only one request is ever outstanding.

Decomposition:
- cpu_pkg contains:
  - opcode constants OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_LW = 6'h23, OP_SW = 6'h2B
  - FUNCT_ADD = 6'h20
  - state enum ctrl_state_t
- Sub-module cpu_next_pc (combinational next-PC select: +1, branch, jump) is natural; the FSM stays in cpu_ctrl_fsm.

Test Plan:
- Reset: assert reset mid-MEM with mem_req=1 -> same cycle mem_req=0, pc=0, state FETCH; release -> fetch_req=1 next cycle.
- R-type add (IR=0x00221820), acks immediate -> rf_we pulse in cycle 4, rf_wa=3, wb_sel=0, pc=1, retire_cnt=1.
- lw with mem_ack delayed 3 cycles -> mem_req high 4 cycles, mem_we=0, then rf_we=1, wb_sel=1, rf_wa=rt; sw -> mem_we=1, no rf_we.
- beq at pc=5, imm=0xFFFE, alu_zero=1 -> pc=4; same with alu_zero=0 -> pc=6; 3 cycles each.
- j addr=0x0000010 from pc=0x40 -> pc=0x10; loop of 2^32 retirements (forced) -> retire_cnt wraps to 0.
- Opcode 6'h3F -> TRAP, illegal=1 held, no fetch_req for 20 cycles until reset.
